// File: rtl/bo_datapath.sv
// bo_datapath: operative block for the JK-style control FSM. Executes one
// micro-operation per clock on RX/RS/RH, captures RS into result on the
// first done cycle and keeps a sticky per-run overflow flag.
module bo_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic [0:1]       m0,
  input  logic [0:1]       m1,
  input  logic [0:1]       m2,
  input  logic             lx,
  input  logic             ls,
  input  logic             lh,
  input  logic             h,
  input  logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0]   rx;
  logic [WIDTH-1:0]   rs;
  logic [WIDTH-1:0]   rh;
  logic               done_q;

  logic [WIDTH-1:0]   mux_a;
  logic [WIDTH-1:0]   mux_b;
  logic [WIDTH-1:0]   alu;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               ovf_event;
  logic               any_load;

  // Operand muxes; bit 0 of each select is the MSB.
  always_comb begin
    unique case ({m0[0], m0[1]})
      2'b00:   mux_a = rx;
      2'b01:   mux_a = rs;
      2'b10:   mux_a = rh;
      default: mux_a = x_in;
    endcase
    unique case ({m1[0], m1[1]})
      2'b00:   mux_b = rx;
      2'b01:   mux_b = rs;
      2'b10:   mux_b = rh;
      default: mux_b = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  end

  // ALU with unsigned wraparound and overflow event detection.
  always_comb begin
    sum       = {1'b0, mux_a} + {1'b0, mux_b};
    prod      = {{WIDTH{1'b0}}, mux_a} * {{WIDTH{1'b0}}, mux_b};
    alu       = mux_a;
    ovf_event = 1'b0;
    unique case ({m2[0], m2[1]})
      2'b00: begin
        alu       = sum[WIDTH-1:0];
        ovf_event = sum[WIDTH];
      end
      2'b01: begin
        alu       = mux_a - mux_b;
        ovf_event = (mux_a < mux_b);
      end
      2'b10: begin
        alu       = prod[WIDTH-1:0];
        ovf_event = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      default: alu = mux_a;
    endcase
  end

  assign any_load = lx | ls | lh;
  assign zero     = (alu == '0);

  // Working registers; all loads use pre-edge ALU/A values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx <= '0;
      rs <= '0;
      rh <= '0;
    end else begin
      if (lx) rx <= alu;
      if (ls) rs <= alu;
      if (lh) rh <= h ? alu : mux_a;
    end
  end

  // Sticky overflow: set on a loaded overflow event, cleared by an idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_event && any_load) begin
      ovf <= 1'b1;
    end else if (!lx) begin
      ovf <= 1'b0;
    end
  end

  // Capture old RS on the rising edge of done, with a single-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      done_q       <= done;
      result_valid <= done && !done_q;
      if (done && !done_q) result <= rs;
    end
  end

endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- Operative block (datapath) driven by the team's 4-bit JK-style control FSM.
- Receives mux selects m0/m1/m2, register loads lx/ls/lh, the h select and done from the controller, and executes one micro-operation per clock on three working registers (RX, RS, RH).
- On the first cycle of done it captures RS into a result register and pulses result_valid for one cycle.
- Tracks a sticky overflow flag per run.

Parameters:
- WIDTH, 8, data width of x_in, RX, RS, RH, ALU and result.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- x_in  in  WIDTH  operand from the host; sampled combinationally through mux A.
- m0  in  [0:1]  mux A select; m0[0] is the MSB.
- m1  in  [0:1]  mux B select; m1[0] is the MSB.
- m2  in  [0:1]  ALU operation select; m2[0] is the MSB.
- lx  in  1  load RX; controller holds lx=0 only in its idle state.
- ls  in  1  load RS.
- lh  in  1  load RH.
- h  in  1  RH source select.
- done  in  1  controller completion level.
- result  out  WIDTH  captured RS value.
- result_valid  out  1  one-cycle pulse when result is updated.
- ovf  out  1  sticky arithmetic overflow for the current run.
- zero  out  1  combinational flag: ALU output == 0.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-run): RX, RS, RH, result = 0; result_valid = 0; ovf = 0; done_q (internal delayed done) = 0. Reset takes priority over every load.
- Mux A, by {m0[0],m0[1]}: 00 RX, 01 RS, 10 RH, 11 x_in.
- Mux B, by {m1[0],m1[1]}: 00 RX, 01 RS, 10 RH, 11 constant 1.
- ALU, by {m2[0],m2[1]}:
  - 00 A+B
  - 01 A-B
  - 10 low WIDTH bits of A*B
  - 11 pass A
- ALU results wrap modulo 2^WIDTH; operands are unsigned.
- Register loads at each rising edge, all from pre-edge values:
  - lx=1: RX <= ALU.
  - ls=1: RS <= ALU.
  - lh=1: RH <= ALU if h=1, else RH <= A.
  - Registers with load=0 hold.
  - Any combination of lx/ls/lh may be active in the same cycle; each loaded register gets the same ALU/A value computed from pre-edge state. No read-after-write forwarding.
- Overflow:
  - Event = op 00 with carry out, op 01 with borrow (A<B), or op 10 with nonzero upper product bits.
  - An event counts only when at least one of lx/ls/lh is 1.
  - ovf set on the edge after the event; stays set until a cycle with lx=0 (idle), which clears it on the next edge. Set has priority if an event and lx=0 coincide (cannot occur, since loads imply non-idle; still defined).
- zero: combinational from the current ALU output; no latency.
- Done handling:
  - done_q <= done every cycle.
  - On an edge where done=1 and done_q=0 (rising detection): result <= RS (pre-edge RS) and result_valid <= 1. Otherwise result_valid <= 0.
  - done held high for N cycles gives exactly one capture and one pulse.
  - If ls=1 in the same cycle as the done rise, result gets the old RS, not the new one.
- Latency: register loads are visible 1 cycle after the control cycle; result and result_valid are visible 1 cycle after the done rise.
- No internal FSM beyond done_q and ovf; all sequencing belongs to the controller.

Test Plan:
- Reset mid-run: load RX=0x55 via {m0=11, m2=11, lx=1}, assert rst asynchronously between edges -> RX, RS, RH, result, ovf, result_valid all 0 immediately, before the next clock edge.
- Add/overflow, WIDTH=8: RX=0xF0, RS=0x20; m0=00, m1=01, m2=00, ls=1 -> RS=0x10 next cycle, ovf=1. Then hold lx=0 for one cycle -> ovf=0.
- Multiply and RH source: RX=0x03, RH=0x07; m0=00, m1=10, m2=10, lh=1, h=1 -> RH=0x15, ovf=0. Repeat with h=0 -> RH=0x03 (value of A).
- Simultaneous loads: RX=0x04; m0=00, m1=11, m2=00, lx=ls=lh=1, h=1 -> RX=RS=RH=0x05 on the same edge.
- Done capture: RS=0x2A, done high for 3 cycles with ls=1, ALU=0x10 in the first done cycle -> result=0x2A, result_valid high exactly 1 cycle, RS=0x10.
- zero/subtract: RX=RS=0x09, m2=01 -> zero=1 combinationally. Then swap to A=0x01, B=0x02 with ls=1 -> RS=0xFF, ovf=1.
